// File: rtl/frame_buffer_writer_if.sv
// frame_buffer_writer_if: pixel stream, vsync and frame buffer write port bundle
interface frame_buffer_writer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              start;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic              pix_ready;
  logic              vga_vs;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_bank;
  logic              rd_bank;
  logic              busy;
  logic              frame_done;
  modport master (
    output start, pix_valid, pix_data, vga_vs,
    input  pix_ready, wr_en, wr_addr, wr_data, wr_bank, rd_bank, busy, frame_done
  );
  modport slave (
    input  start, pix_valid, pix_data, vga_vs,
    output pix_ready, wr_en, wr_addr, wr_data, wr_bank, rd_bank, busy, frame_done
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: raster-order pixel writer into a double-banked frame buffer
module frame_buffer_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8
) (
  input  logic clk,
  input  logic reset,
  frame_buffer_writer_if.slave bus
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;
  state_t            r_state;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_rd_bank;
  logic              r_vs_d;
  logic              w_ready;
  logic              w_beat;
  logic              w_x_last;
  logic              w_y_last;
  assign w_ready  = r_state == WRITE;
  assign w_beat   = bus.pix_valid & w_ready;
  assign w_x_last = r_x == XW'(H_ACTIVE - 1);
  assign w_y_last = r_y == YW'(V_ACTIVE - 1);
  assign bus.pix_ready  = w_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.rd_bank    = r_rd_bank;
  assign bus.wr_bank    = ~r_rd_bank;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_addr       <= '0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_vs_d       <= 1'b1;
    end else begin
      r_vs_d       <= bus.vga_vs;
      r_wr_en      <= w_beat;
      r_frame_done <= 1'b0;
      if (w_beat) begin
        r_wr_data <= bus.pix_data;
        r_wr_addr <= r_addr;
        r_addr    <= r_addr + 1'b1;
        r_x       <= w_x_last ? '0 : r_x + 1'b1;
        r_y       <= w_x_last ? r_y + 1'b1 : r_y;
        if (w_x_last && w_y_last) r_state <= WAIT_SWAP;
      end
      if (r_state == IDLE && bus.start) begin
        r_state <= WRITE;
        r_x     <= '0;
        r_y     <= '0;
        r_addr  <= '0;
        r_busy  <= 1'b1;
      end
      // swap only on a vsync fall seen after the frame is complete
      if (r_state == WAIT_SWAP && r_vs_d && !bus.vga_vs) begin
        r_state      <= IDLE;
        r_rd_bank    <= ~r_rd_bank;
        r_frame_done <= 1'b1;
        r_busy       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: randomized scoreboard bench for the frame buffer writer
module tb_frame_buffer_writer;
  localparam int H = 4, V = 3, N = H * V, AW = 4, DW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;
  frame_buffer_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  frame_buffer_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  typedef struct {int addr; int data; int cyc;} wr_t;
  wr_t q[$];
  int compared = 0, mismatched = 0, cyc = 0, count = 0, exp_rd = 0;
  bit capturing = 0;
  always @(posedge clk) cyc++;
  task automatic chk(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_en) begin
        if (q.size() == 0) chk("spurious_wr_en", 1, 0);
        else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", int'(bus.wr_addr), e.addr);
          chk("wr_data", int'(bus.wr_data), e.data);
          chk("wr_latency", cyc, e.cyc);
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) chk("missing_wr_en", 0, 1);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle(string tag);
    chk({tag, "_pix_ready"}, int'(bus.pix_ready), 0);
    chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_rd_bank"}, int'(bus.rd_bank), exp_rd);
    chk({tag, "_wr_bank"}, int'(bus.wr_bank), 1 - exp_rd);
    chk({tag, "_frame_done"}, int'(bus.frame_done), 0);
  endtask
  task automatic frame(int mode, bit vs_last, bit noise, int limit);
    bit v;
    int x, y;
    bus.start = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_data = 8'hEE;
    tick();
    bus.start = 1'b0;
    capturing = 1;
    count = 0;
    for (int g = 0; g < 2000 && capturing && count < limit; g++) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (g % 2 == 0) : 1'($urandom % 2);
      bus.pix_valid = v;
      bus.pix_data = (mode < 2 && v) ? 8'(8'h10 + count) : 8'($urandom);
      bus.start = noise && ($urandom % 4 == 0);
      chk("write_pix_ready", int'(bus.pix_ready), 1);
      chk("write_busy", int'(bus.busy), 1);
      if (v) begin
        x = count % H;
        y = count / H;
        q.push_back('{y * H + x, int'(bus.pix_data), cyc + 1});
        count++;
        if (count == N) begin
          capturing = 0;
          if (vs_last) bus.vga_vs = 1'b0;
        end
      end
      tick();
    end
    bus.start = 1'b0;
    if (count < limit) chk("frame_timeout", count, limit);
    if (limit == N) begin
      bus.pix_valid = 1'b1;
      chk("wait_pix_ready", int'(bus.pix_ready), 0);
      chk("wait_busy", int'(bus.busy), 1);
    end
  endtask
  task automatic swap(int pre, bit start_same);
    for (int i = 0; i < pre; i++) begin
      tick();
      chk("noswap_frame_done", int'(bus.frame_done), 0);
      chk("noswap_rd_bank", int'(bus.rd_bank), exp_rd);
      chk("noswap_busy", int'(bus.busy), 1);
    end
    bus.vga_vs = 1'b1;
    tick();
    chk("pre_fall_frame_done", int'(bus.frame_done), 0);
    bus.vga_vs = 1'b0;
    bus.start = start_same;
    tick();
    bus.start = 1'b0;
    exp_rd = 1 - exp_rd;
    chk("swap_frame_done", int'(bus.frame_done), 1);
    chk("swap_rd_bank", int'(bus.rd_bank), exp_rd);
    chk("swap_wr_bank", int'(bus.wr_bank), 1 - exp_rd);
    chk("swap_busy", int'(bus.busy), 0);
    bus.vga_vs = 1'b1;
    tick();
    bus.pix_valid = 1'b0;
    check_idle("post_swap");
  endtask
  initial begin
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.vga_vs = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check_idle("reset");
    frame(0, 1'b0, 1'b0, N);
    swap(3, 1'b0);
    frame(1, 1'b0, 1'b0, N);
    swap(2, 1'b1);
    frame(2, 1'b1, 1'b1, N);
    swap(20, 1'b0);
    frame(2, 1'b0, 1'b0, 5);
    bus.pix_valid = 1'b0;
    #5 reset = 1'b1;
    #1;
    q.delete();
    exp_rd = 0;
    capturing = 0;
    chk("midreset_rd_bank", int'(bus.rd_bank), 0);
    chk("midreset_wr_bank", int'(bus.wr_bank), 1);
    chk("midreset_wr_en", int'(bus.wr_en), 0);
    chk("midreset_busy", int'(bus.busy), 0);
    repeat (2) tick();
    reset = 1'b0;
    check_idle("after_reset");
    frame(2, 1'b0, 1'b1, N);
    swap(1, 1'b0);
    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Write-side counterpart of the VGA pixel reader. It accepts a filtered 8-bit pixel stream over a valid/ready handshake and writes each pixel into a double-banked frame buffer in raster order.
- The VGA side reads one bank while this block fills the other.
- Banks swap only at the first vsync assertion after a complete frame, so the display never shows a partially written image.
- Sits between the image filter pipeline and the frame buffer RAM, in the 25 MHz pixel clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 19, frame buffer address width; must satisfy H_ACTIVE*V_ACTIVE <= 2^ADDR_W
- DATA_W, 8, pixel width

Ports:
- clk  in  1  pixel clock (25 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begin capturing a new frame
- pix_valid  in  1  pix_data holds a valid pixel
- pix_data  in  DATA_W  pixel value
- pix_ready  out  1  block accepts a pixel this cycle
- vga_vs  in  1  vertical sync from the VGA interface, active-low
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  linear RAM address, y*H_ACTIVE+x
- wr_data  out  DATA_W  RAM write data
- wr_bank  out  1  bank being written; always ~rd_bank
- rd_bank  out  1  bank the VGA side reads
- busy  out  1  high in WRITE and WAIT_SWAP
- frame_done  out  1  single-cycle pulse on bank swap

Behaviour:
Reset values (asynchronous, active-high):
- state=IDLE; pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0
- rd_bank=0, wr_bank=1; x=0, y=0
- vs_d=1 (previous-cycle copy of vga_vs)

States:
- IDLE
  - pix_ready=0.
  - start=1 -> WRITE next cycle; x, y and address counter cleared to 0.
- WRITE
  - pix_ready=1 combinationally in this state.
  - Beat = pix_valid & pix_ready.
  - On a beat: next cycle wr_en=1, wr_data=pix_data, wr_addr=current address counter. Fixed latency of 1 cycle from acceptance to write strobe.
  - wr_en=0 in any cycle following a non-beat cycle; bubbles in pix_valid are allowed.
- Counter stepping (on each beat)
  - Address counter +1.
  - x+1, except at x=H_ACTIVE-1: x wraps to 0 and y+1.
  - On the beat with x=H_ACTIVE-1 and y=V_ACTIVE-1 (last pixel): go to WAIT_SWAP and deassert pix_ready from the next cycle. The final wr_en still fires in the first WAIT_SWAP cycle.
- WAIT_SWAP
  - pix_ready=0; vs_d registered every cycle in all states.
  - Falling edge (vs_d=1 and vga_vs=0) -> toggle rd_bank and wr_bank, pulse frame_done for one cycle, go to IDLE.
  - Edge detection is evaluated only in WAIT_SWAP.

Boundary rules:
- start while busy: ignored; no counter change.
- start in the same cycle as the IDLE transition from WAIT_SWAP: ignored (state is still WAIT_SWAP).
- vsync falling edge in the same cycle as the last-pixel beat: not a swap. The block waits for the next falling edge.
- vga_vs held low on entering WAIT_SWAP: no swap until it goes high and falls again.
- Address arithmetic is a plain counter with no multiplier. Maximum address is H_ACTIVE*V_ACTIVE-1 (307199 at defaults) and never wraps within a frame.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is abandoned and rd_bank returns to 0.
- pix_data is sampled only on beats; a held pix_valid outside WRITE is never consumed.

Test Plan:
1. Reset sequence.
   - Assert reset for 3 cycles, deassert.
   - Required: pix_ready=0, wr_en=0, busy=0, rd_bank=0, wr_bank=1, frame_done=0.
2. Continuous stream (H_ACTIVE=4, V_ACTIVE=3).
   - start, then pix_valid=1 for 12 cycles with data 0x10..0x1B.
   - Required: wr_en high for 12 consecutive cycles, each one cycle after its beat; wr_addr 0..11 with data 0x10..0x1B; pix_ready drops after the 12th beat.
   - Then vga_vs 1->0: rd_bank=1, wr_bank=0, one-cycle frame_done, busy=0.
3. Bubbles.
   - Same frame with pix_valid alternating 1/0.
   - Required: exactly 12 wr_en strobes, addresses 0..11 in order, no write on idle cycles; line wrap at x=3 gives address 4 for (x=0, y=1).
4. Simultaneous events.
   - Falling vga_vs in the same cycle as the last beat.
   - Required: no swap.
   - Second falling edge 20 cycles later: swap and frame_done.
   - start pulsed mid-WRITE: addresses unaffected.
5. Reset mid-frame.
   - Reset asserted after 5 beats of the second frame (rd_bank=1).
   - Required: immediate return to rd_bank=0, wr_en=0.
   - A new start writes from wr_addr 0.
6. Default geometry.
   - 307200 beats.
   - Required: last write at wr_addr 307199 with x/y wrap correct, then swap on vsync.
